// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte-stream UART transmitter, 8N1, LSB first, fed from a
// small circular FIFO.
//   clk        - system clock, all logic on the rising edge
//   reset      - asynchronous, active-low reset
//   in_data    - byte to transmit
//   in_valid   - in_data valid; accepted when in_valid && in_ready at an edge
//   in_ready   - FIFO has room (registered count below FIFO_DEPTH)
//   txd        - serial line, idle high
//   busy       - high while a frame (start/data/stop) is on the line
//   tx_done    - one-cycle pulse on the last cycle of each stop bit
//   fifo_count - bytes currently stored, 0..FIFO_DEPTH
module uart_tx_fifo #(
  parameter int unsigned  CLKS_PER_BIT = 434,
  parameter int unsigned  FIFO_DEPTH   = 16,
  localparam int unsigned CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             txd,
  output logic             busy,
  output logic             tx_done,
  output logic [CNT_W-1:0] fifo_count
);

  localparam int unsigned      PTR_W      = $clog2(FIFO_DEPTH);
  localparam logic [15:0]      BIT_LAST   = 16'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  state_e           state_q, state_d;
  logic [15:0]      bit_cnt_q, bit_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             busy_q, busy_d;
  logic             tx_done_q, tx_done_d;
  logic             push, pop, bit_end;

  assign in_ready   = (count_q != FULL_COUNT);
  assign push       = in_valid && in_ready;
  assign bit_end    = (bit_cnt_q == BIT_LAST);
  assign txd        = txd_q;
  assign busy       = busy_q;
  assign tx_done    = tx_done_q;
  assign fifo_count = count_q;

  // FIFO bookkeeping; pointers wrap naturally at FIFO_DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  // Next-state logic. A pop is only taken from IDLE, so IDLE lasts exactly
  // one cycle between back-to-back frames.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        bit_idx_d = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          state_d   = DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line outputs are registered from the current state, so the line trails
  // the FSM by one cycle: pop at edge N+1 puts the start bit out from N+2,
  // and tx_done lands on the last stop cycle seen on txd.
  always_comb begin
    txd_d     = 1'b1;
    busy_d    = 1'b0;
    tx_done_d = 1'b0;
    case (state_q)
      START: begin
        txd_d  = 1'b0;
        busy_d = 1'b1;
      end
      DATA: begin
        txd_d  = shift_q[0];
        busy_d = 1'b1;
      end
      STOP: begin
        busy_d    = 1'b1;
        tx_done_d = bit_end;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
      tx_done_q <= tx_done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo. Three instances share one
// clock: A at default parameters, B with a short bit period for FIFO
// fill/wrap scenarios, C at the minimum parameters. A serial receiver per
// instance decodes txd and records bytes, start-bit cycles and pulse counts.
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  logic [7:0] data_a = 8'h00, data_b = 8'h00, data_c = 8'h00;
  logic       valid_a = 1'b0, valid_b = 1'b0, valid_c = 1'b0;
  logic       ready_a, ready_b, ready_c;
  logic       txd_a, txd_b, txd_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;
  logic [4:0] count_a, count_b;
  logic [1:0] count_c;

  uart_tx_fifo dut_a (
    .clk(clk), .reset(rst_a), .in_data(data_a), .in_valid(valid_a),
    .in_ready(ready_a), .txd(txd_a), .busy(busy_a), .tx_done(done_a),
    .fifo_count(count_a)
  );

  uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(16)) dut_b (
    .clk(clk), .reset(rst_b), .in_data(data_b), .in_valid(valid_b),
    .in_ready(ready_b), .txd(txd_b), .busy(busy_b), .tx_done(done_b),
    .fifo_count(count_b)
  );

  uart_tx_fifo #(.CLKS_PER_BIT(2), .FIFO_DEPTH(2)) dut_c (
    .clk(clk), .reset(rst_c), .in_data(data_c), .in_valid(valid_c),
    .in_ready(ready_c), .txd(txd_c), .busy(busy_c), .tx_done(done_c),
    .fifo_count(count_c)
  );

  logic [2:0] txd_v, done_v, busy_v;
  assign txd_v  = {txd_c, txd_b, txd_a};
  assign done_v = {done_c, done_b, done_a};
  assign busy_v = {busy_c, busy_b, busy_a};

  int       cpb [3] = '{434, 4, 2};
  int       rx_act [3];
  int       rx_cnt [3];
  bit [7:0] rx_sh [3];
  bit [7:0] rx_buf [3][128];
  int       rx_n [3];
  int       st_t [3][128];
  int       st_n [3];
  int       rx_err [3];
  int       done_n [3];
  int       busy_n [3];

  int n_pass = 0;
  int n_tot  = 0;

  // Receivers sample on the falling clock edge, mid-bit.
  initial begin
    forever begin
      @(negedge clk);
      for (int r = 0; r < 3; r++) begin
        if (done_v[r] === 1'b1) done_n[r]++;
        if (busy_v[r] === 1'b1) busy_n[r]++;
        if (rx_act[r] == 0) begin
          if (txd_v[r] === 1'b0) begin
            rx_act[r] = 1;
            rx_cnt[r] = 0;
            if (st_n[r] < 128) st_t[r][st_n[r]] = cyc;
            st_n[r]++;
          end
        end else begin
          rx_cnt[r]++;
        end
        if (rx_act[r] == 1 && (rx_cnt[r] % cpb[r]) == cpb[r] / 2) begin
          if (rx_cnt[r] / cpb[r] == 0) begin
            if (txd_v[r] !== 1'b0) begin
              rx_err[r]++;
              rx_act[r] = 0;
            end
          end else if (rx_cnt[r] / cpb[r] <= 8) begin
            rx_sh[r] = {txd_v[r], rx_sh[r][7:1]};
          end else begin
            if (txd_v[r] !== 1'b1) rx_err[r]++;
            if (rx_n[r] < 128) rx_buf[r][rx_n[r]] = rx_sh[r];
            rx_n[r]++;
            rx_act[r] = 0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    #40;
    n_tot++; if (txd_a !== 1'b1) $display("FAIL reset_txd: got %b want 1", txd_a); else n_pass++;
    n_tot++; if (busy_a !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_a); else n_pass++;
    n_tot++; if (done_a !== 1'b0) $display("FAIL reset_tx_done: got %b want 0", done_a); else n_pass++;
    n_tot++; if (count_a !== 5'd0) $display("FAIL reset_count: got %0d want 0", count_a); else n_pass++;
    n_tot++; if (ready_a !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", ready_a); else n_pass++;
    n_tot++; if (txd_c !== 1'b1 || count_c !== 2'd0) $display("FAIL reset_c: txd %b count %0d want 1 0", txd_c, count_c); else n_pass++;
    #60;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    tick();
  endtask

  task automatic test_single_byte();
    bit [7:0] b = 8'h41;
    int base_rx = rx_n[0], base_done = done_n[0], base_err = rx_err[0];
    int bad_txd = 0, bad_busy = 0, bad_done = 0, first_bad = -1;
    logic e_txd, e_busy, e_done;
    data_a = b; valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    n_tot++; if (count_a !== 5'd1) $display("FAIL single_count_push: got %0d want 1", count_a); else n_pass++;
    for (int k = 1; k <= 4345; k++) begin
      tick();
      if (k < 2)         e_txd = 1'b1;
      else if (k < 436)  e_txd = 1'b0;
      else if (k < 3908) e_txd = b[(k - 436) / 434];
      else               e_txd = 1'b1;
      e_busy = (k >= 2 && k <= 4341);
      e_done = (k == 4341);
      if (txd_a !== e_txd) begin
        if (bad_txd == 0) first_bad = k;
        bad_txd++;
      end
      if (busy_a !== e_busy) bad_busy++;
      if (done_a !== e_done) bad_done++;
      if (k == 1) begin
        n_tot++; if (count_a !== 5'd0) $display("FAIL single_count_pop: got %0d want 0", count_a); else n_pass++;
      end
    end
    n_tot++; if (bad_txd != 0) $display("FAIL single_txd_wave: %0d bad cycles (first k=%0d) want 0", bad_txd, first_bad); else n_pass++;
    n_tot++; if (bad_busy != 0) $display("FAIL single_busy_wave: %0d bad cycles want 0", bad_busy); else n_pass++;
    n_tot++; if (bad_done != 0) $display("FAIL single_tx_done_wave: %0d bad cycles want 0", bad_done); else n_pass++;
    n_tot++; if (rx_n[0] - base_rx != 1 || rx_buf[0][base_rx] !== b)
      $display("FAIL single_rx: got %0d bytes first %h want 1 byte 41", rx_n[0] - base_rx, rx_buf[0][base_rx]);
    else n_pass++;
    n_tot++; if (done_n[0] - base_done != 1 || rx_err[0] != base_err)
      $display("FAIL single_pulses: tx_done %0d framing errs %0d want 1 0", done_n[0] - base_done, rx_err[0] - base_err);
    else n_pass++;
    $display("receiver A: \"%c\"", rx_buf[0][base_rx]);
  endtask

  task automatic test_string();
    bit [7:0] msg [5] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    int base_rx = rx_n[0], base_st = st_n[0], base_done = done_n[0], base_err = rx_err[0];
    int peak = 0, bad_rx = 0, bad_gap = 0;
    for (int i = 0; i < 5; i++) begin
      data_a = msg[i]; valid_a = 1'b1;
      tick();
      if (int'(count_a) > peak) peak = int'(count_a);
    end
    valid_a = 1'b0;
    n_tot++; if (count_a !== 5'd4) $display("FAIL string_count_after_push: got %0d want 4", count_a); else n_pass++;
    for (int t = 0; t < 5 * 4341 + 600 && rx_n[0] - base_rx < 5; t++) begin
      tick();
      if (int'(count_a) > peak) peak = int'(count_a);
    end
    repeat (300) tick();
    n_tot++; if (peak != 4) $display("FAIL string_peak_count: got %0d want 4", peak); else n_pass++;
    for (int i = 0; i < 5; i++) if (rx_buf[0][base_rx + i] !== msg[i]) bad_rx++;
    n_tot++; if (rx_n[0] - base_rx != 5 || bad_rx != 0)
      $display("FAIL string_rx: got %0d bytes %0d wrong want 5 0", rx_n[0] - base_rx, bad_rx);
    else n_pass++;
    for (int i = 0; i < 4; i++) if (st_t[0][base_st + i + 1] - st_t[0][base_st + i] != 4341) bad_gap++;
    n_tot++; if (st_n[0] - base_st != 5 || bad_gap != 0)
      $display("FAIL string_start_spacing: %0d starts %0d gaps off want 5 0 (gap0=%0d want 4341)",
               st_n[0] - base_st, bad_gap, st_t[0][base_st + 1] - st_t[0][base_st]);
    else n_pass++;
    n_tot++; if (done_n[0] - base_done != 5 || rx_err[0] != base_err)
      $display("FAIL string_pulses: tx_done %0d framing errs %0d want 5 0", done_n[0] - base_done, rx_err[0] - base_err);
    else n_pass++;
    $display("receiver A: \"%c%c%c%c%c\"", rx_buf[0][base_rx], rx_buf[0][base_rx + 1],
             rx_buf[0][base_rx + 2], rx_buf[0][base_rx + 3], rx_buf[0][base_rx + 4]);
  endtask

  task automatic test_reset_mid_frame();
    bit [7:0] bytes [6] = '{8'h55, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    int base_st, bad = 0;
    for (int i = 0; i < 6; i++) begin
      data_a = bytes[i]; valid_a = 1'b1;
      tick();
    end
    valid_a = 1'b0;
    n_tot++; if (count_a !== 5'd5) $display("FAIL mid_queued: got %0d want 5", count_a); else n_pass++;
    // Edge N+1900 lies inside data bit 3 (line cycles 1738..2171), which is 0.
    repeat (1895) tick();
    n_tot++; if (txd_a !== 1'b0) $display("FAIL mid_bit3_low: got %b want 0", txd_a); else n_pass++;
    base_st = st_n[0];
    #1 rst_a = 1'b0;
    #1;
    n_tot++; if (txd_a !== 1'b1 || busy_a !== 1'b0) $display("FAIL mid_async_line: txd %b busy %b want 1 0", txd_a, busy_a); else n_pass++;
    n_tot++; if (count_a !== 5'd0 || ready_a !== 1'b1) $display("FAIL mid_async_fifo: count %0d ready %b want 0 1", count_a, ready_a); else n_pass++;
    tick(); tick();
    rst_a = 1'b1;
    for (int t = 0; t < 3000; t++) begin
      tick();
      if (txd_a !== 1'b1 || busy_a !== 1'b0 || count_a !== 5'd0) bad++;
    end
    n_tot++; if (bad != 0) $display("FAIL mid_quiet_after_release: %0d bad cycles want 0", bad); else n_pass++;
    n_tot++; if (st_n[0] != base_st) $display("FAIL mid_no_new_frame: got %0d starts want 0", st_n[0] - base_st); else n_pass++;
  endtask

  task automatic test_full_fifo();
    int base_rx = rx_n[1], base_err = rx_err[1];
    int idx = 0, maxc = 0, bad_ready = 0, bad_rx = 0, prevc = 0, refill = 0;
    bit saw_block = 1'b0;
    logic acc;
    for (int t = 0; t < 3000 && idx < 40; t++) begin
      data_b = 8'h10 + 8'(idx); valid_b = 1'b1;
      acc = ready_b;
      if (int'(count_b) > maxc) maxc = int'(count_b);
      if (ready_b !== (count_b != 5'd16)) bad_ready++;
      if (count_b == 5'd16 && ready_b == 1'b0) saw_block = 1'b1;
      if (refill == 1) refill = (count_b == 5'd16) ? 3 : 2;
      else if (refill == 0 && prevc == 16 && count_b == 5'd15) refill = 1;
      prevc = int'(count_b);
      tick();
      if (acc === 1'b1) idx++;
    end
    valid_b = 1'b0;
    for (int t = 0; t < 2500 && rx_n[1] - base_rx < 40; t++) tick();
    n_tot++; if (maxc != 16) $display("FAIL full_max_count: got %0d want 16", maxc); else n_pass++;
    n_tot++; if (saw_block != 1'b1) $display("FAIL full_in_ready_low: got %b want 1", saw_block); else n_pass++;
    n_tot++; if (bad_ready != 0) $display("FAIL full_in_ready_track: %0d bad cycles want 0", bad_ready); else n_pass++;
    n_tot++; if (refill != 3) $display("FAIL full_refill_next_cycle: state %0d want 3", refill); else n_pass++;
    for (int i = 0; i < 40; i++) if (rx_buf[1][base_rx + i] !== 8'h10 + 8'(i)) bad_rx++;
    n_tot++; if (rx_n[1] - base_rx != 40 || bad_rx != 0 || rx_err[1] != base_err)
      $display("FAIL full_order: got %0d bytes %0d wrong %0d errs want 40 0 0", rx_n[1] - base_rx, bad_rx, rx_err[1] - base_err);
    else n_pass++;
    for (int t = 0; t < 200 && (busy_b !== 1'b0 || count_b !== 5'd0); t++) tick();
    repeat (10) tick();
  endtask

  task automatic test_simul_push_pop();
    bit [7:0] exp [5] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB7};
    int base_rx = rx_n[1], bad_rx = 0;
    for (int i = 0; i < 4; i++) begin
      data_b = exp[i]; valid_b = 1'b1;
      tick();
    end
    valid_b = 1'b0;
    repeat (38) tick();
    n_tot++; if (count_b !== 5'd3 || txd_b !== 1'b1) $display("FAIL simul_before_pop: count %0d txd %b want 3 1", count_b, txd_b); else n_pass++;
    data_b = exp[4]; valid_b = 1'b1;
    tick();
    valid_b = 1'b0;
    n_tot++; if (count_b !== 5'd3) $display("FAIL simul_count_held: got %0d want 3", count_b); else n_pass++;
    tick();
    n_tot++; if (txd_b !== 1'b0 || busy_b !== 1'b1) $display("FAIL simul_next_start: txd %b busy %b want 0 1", txd_b, busy_b); else n_pass++;
    for (int t = 0; t < 400 && rx_n[1] - base_rx < 5; t++) tick();
    for (int i = 0; i < 5; i++) if (rx_buf[1][base_rx + i] !== exp[i]) bad_rx++;
    n_tot++; if (rx_n[1] - base_rx != 5 || bad_rx != 0)
      $display("FAIL simul_order: got %0d bytes %0d wrong, last %h want 5 0 b7", rx_n[1] - base_rx, bad_rx, rx_buf[1][base_rx + 4]);
    else n_pass++;
  endtask

  task automatic test_edge_params();
    bit [7:0] exp [4] = '{8'h00, 8'hFF, 8'h5A, 8'h33};
    int base_rx = rx_n[2], base_st = st_n[2], base_busy = busy_n[2], base_done = done_n[2];
    int edge_n = 3, bad_rx = 0, bad_gap = 0;
    logic acc;
    for (int i = 0; i < 3; i++) begin
      data_c = exp[i]; valid_c = 1'b1;
      tick();
    end
    n_tot++; if (count_c !== 2'd2 || ready_c !== 1'b0) $display("FAIL edge_full: count %0d ready %b want 2 0", count_c, ready_c); else n_pass++;
    data_c = exp[3];
    tick();
    n_tot++; if (count_c !== 2'd2) $display("FAIL edge_full_hold: got %0d want 2", count_c); else n_pass++;
    edge_n = 4;
    for (int t = 0; t < 60; t++) begin
      acc = ready_c;
      tick();
      if (acc === 1'b1) break;
      edge_n++;
    end
    valid_c = 1'b0;
    n_tot++; if (edge_n != 23) $display("FAIL edge_accept_edge: got N+%0d want N+23", edge_n); else n_pass++;
    for (int t = 0; t < 200 && rx_n[2] - base_rx < 4; t++) tick();
    repeat (10) tick();
    for (int i = 0; i < 4; i++) if (rx_buf[2][base_rx + i] !== exp[i]) bad_rx++;
    n_tot++; if (rx_n[2] - base_rx != 4 || bad_rx != 0)
      $display("FAIL edge_rx: got %0d bytes %0d wrong want 4 0", rx_n[2] - base_rx, bad_rx);
    else n_pass++;
    for (int i = 0; i < 3; i++) if (st_t[2][base_st + i + 1] - st_t[2][base_st + i] != 21) bad_gap++;
    n_tot++; if (st_n[2] - base_st != 4 || bad_gap != 0)
      $display("FAIL edge_period: %0d starts %0d gaps off want 4 0", st_n[2] - base_st, bad_gap);
    else n_pass++;
    n_tot++; if (busy_n[2] - base_busy != 80) $display("FAIL edge_busy_cycles: got %0d want 80", busy_n[2] - base_busy); else n_pass++;
    n_tot++; if (done_n[2] - base_done != 4 || rx_err[2] != 0)
      $display("FAIL edge_pulses: tx_done %0d errs %0d want 4 0", done_n[2] - base_done, rx_err[2]);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_string();
    test_reset_mid_frame();
    test_full_fifo();
    test_simul_push_pop();
    test_edge_params();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte-stream UART transmitter: buffers bytes from the processing fabric in a small FIFO and serialises them 8N1, LSB first, onto the uart txd line. It is the stage directly upstream of the serial receiver that monitors the SoC's txd pin. Line rate is 230400 baud from a 100 MHz clock.

Parameters:
CLKS_PER_BIT, 434, clock cycles per serial bit (100000000/230400, truncated); legal range 2..65535
FIFO_DEPTH, 16, byte entries; power of 2, at least 2
CNT_W, $clog2(FIFO_DEPTH)+1, width of fifo_count (derived, not overridden)

Ports:
clk  input  1  single system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset; deasserts synchronously to clk at system level
in_data  input  8  byte to transmit
in_valid  input  1  in_data valid
in_ready  output  1  FIFO can accept; a byte is accepted when in_valid && in_ready at a rising edge
txd  output  1  serial line, idle high
busy  output  1  high while a frame (start/data/stop) is on the line
tx_done  output  1  one-cycle pulse on the last cycle of each stop bit
fifo_count  output  CNT_W  bytes currently stored, 0..FIFO_DEPTH

Behaviour:
- Reset (reset=0): asynchronously forces txd=1, busy=0, tx_done=0, fifo_count=0, in_ready=1, state=IDLE, pointers=0. Clears a frame in flight immediately; no partial frame resumes after release.
- in_ready = (fifo_count != FIFO_DEPTH), driven from registered count. A byte offered while full is not accepted and stays pending at the source.
- Read/write pointers are log2(FIFO_DEPTH) bits wide and wrap naturally. fifo_count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Pop occurs only in IDLE when fifo_count != 0. The popped byte loads the shift register, and state goes to START on the next edge.
- Latency: byte accepted into an empty FIFO while IDLE at edge N -> popped at edge N+1 -> txd=0 from edge N+2.
- FSM (registered txd; bit counter 0..CLKS_PER_BIT-1):
  IDLE: txd=1, busy=0. On pop -> START.
  START: txd=0 for CLKS_PER_BIT cycles -> DATA.
  DATA: txd=shift[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit. Bit index 0..7; after bit 7 -> STOP.
  STOP: txd=1 for CLKS_PER_BIT cycles. tx_done=1 on its final cycle -> IDLE.
- busy=1 in START, DATA and STOP.
- Back-to-back: IDLE lasts exactly one cycle between frames when the FIFO is non-empty. Frame period is 10*CLKS_PER_BIT+1 cycles (4341 at default).
- Push during a frame is allowed, including into the slot freed by that cycle's pop.
- Bit-period counter width is 16 bits. Its terminal compare is CLKS_PER_BIT-1.
- No glitches on txd: it changes only at bit boundaries.

Test Plan:
- Single byte: reset low for 100 ns, then release. Push 0x41 at edge N -> txd=0 for cycles N+2..N+435. Data bits follow as 1,0,0,0,0,0,1,0, each 434 cycles. Stop is high for 434 cycles. tx_done pulses once, busy falls with the stop, and the bench receiver prints "A".
- String: push "Hello" (0x48 0x65 0x6C 0x6C 0x6F) in consecutive cycles -> fifo_count peaks at 4. Start-bit falling edges are spaced exactly 4341 cycles apart. Receiver prints "Hello" and tx_done pulses 5 times.
- Full FIFO: hold in_valid with txd busy, 17+ bytes offered -> fifo_count reaches 16 and in_ready=0. The 17th byte stays pending and is accepted the cycle after the next pop. Count returns to 16, no byte is lost or duplicated, and the wrap-around order is preserved across 40 bytes.
- Simultaneous push/pop: push on the exact edge of a pop with count=3 -> count stays 3, and the pushed byte is sent last.
- Reset mid-frame: assert reset during data bit 3 of 0x55 with 5 bytes queued -> txd=1 and fifo_count=0 immediately, in the same cycle without waiting for an edge. After release, txd stays 1 with no frame emitted until a new push.
- Edge parameters: CLKS_PER_BIT=2 and FIFO_DEPTH=2 -> frame of 20 cycles, period 21, in_ready low after 2 stored bytes. Bytes 0x00 and 0xFF are received correctly.
